retire_trace_fifo: RTL and testbench

- Synthesizable companion to the simulation pipeline logger; taps the memory-to-writeback handshake (passive monitor, never drives it).
- Timestamps each retired instruction and buffers the record in a FIFO.
- Streams records out over a valid/ready port to a debug/trace sink, so retirement traces can be captured on hardware where file logging is unavailable.

---
 rtl/retire_trace_fifo.sv | 134 +++++++++++++
 tb/tb_retire_trace_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_fifo.sv
// rtl/retire_trace_fifo.sv - retirement trace capture FIFO with valid/ready record stream
//
// Passively watches the memory-to-writeback handshake. It stamps every retired
// instruction with a free-running cycle count, buffers the record, and streams
// it to a trace sink.
//
// Optional build macro: RETIRE_TRACE_FILTER_EN adds an opcode match filter.
//
// Ports:
//   clk, rst          core clock; asynchronous active-low reset
//   enable            capture enable (draining and the cycle counter keep running)
//   mon_tvalid/tready monitored writeback handshake (inputs only, never driven)
//   mon_pc/opcode/rd  retiring instruction fields
//   mon_data          result written back
//   filter_opcode     (RETIRE_TRACE_FILTER_EN) opcode to match
//   filter_mask       (RETIRE_TRACE_FILTER_EN) bits of the opcode that take part in the match
//   trace_tvalid      head record available
//   trace_tready      sink accepts the head record
//   trace_tdata       {cycle, pc, opcode, rd, data}, MSB first
//   level             current FIFO occupancy
//   drop_count        records lost to overflow, saturating

module retire_trace_fifo #(
   parameter int DEPTH       = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int CYCLE_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              mon_tvalid,
   input  logic                              mon_tready,
   input  logic [31:0]                       mon_pc,
   input  logic [6:0]                        mon_opcode,
   input  logic [4:0]                        mon_rd,
   input  logic [DATA_WIDTH-1:0]             mon_data,
`ifdef RETIRE_TRACE_FILTER_EN
   input  logic [6:0]                        filter_opcode,
   input  logic [6:0]                        filter_mask,
`endif
   output logic                              trace_tvalid,
   input  logic                              trace_tready,
   output logic [CYCLE_WIDTH+44+DATA_WIDTH-1:0] trace_tdata,
   output logic [$clog2(DEPTH):0]            level,
   output logic [15:0]                       drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = CYCLE_WIDTH + 44 + DATA_WIDTH;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic [15:0]            drop_q, drop_d;

   // Record storage is not reset: the level register alone decides which
   // entries are live, so stale contents after a reset are never shown.
   logic [RW-1:0]          mem_q [DEPTH];

   logic          filter_hit;
   logic          capture;
   logic          pop;
   logic          full;
   logic          push;
   logic          drop;
   logic [RW-1:0] rec;

`ifdef RETIRE_TRACE_FILTER_EN
   assign filter_hit = ((mon_opcode & filter_mask) == (filter_opcode & filter_mask));
`else
   assign filter_hit = 1'b1;
`endif

   always_comb begin
      capture = enable & mon_tvalid & mon_tready & filter_hit;
      pop     = (level_q != '0) & trace_tready;
      full    = (level_q == DEPTH_L);
      // A pop in the same cycle frees the slot, so a full FIFO can still
      // accept; an empty FIFO never pops, so capture always wins there.
      push    = capture & (~full | pop);
      drop    = capture & ~push;
      rec     = {cycle_q, mon_pc, mon_opcode, mon_rd, mon_data};

      cycle_d  = cycle_q + CYCLE_WIDTH'(1);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      drop_d = drop_q;
      if (drop && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
      end else begin
         cycle_q  <= cycle_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rec;
      end
   end

   // Output is gated by the async-reset level so the record bus reads zero
   // immediately on reset and whenever nothing is buffered. The head entry
   // only changes on a pop, which keeps tdata stable under backpressure.
   assign trace_tvalid = (level_q != '0);
   assign trace_tdata  = trace_tvalid ? mem_q[rd_ptr_q] : '0;
   assign level        = level_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb/tb_retire_trace_fifo.sv - scoreboard testbench for retire_trace_fifo
module tb_retire_trace_fifo;

   localparam int RW = 108;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          mon_tvalid = 1'b0;
   logic          mon_tready = 1'b0;
   logic [31:0]   mon_pc = '0;
   logic [6:0]    mon_opcode = '0;
   logic [4:0]    mon_rd = '0;
   logic [31:0]   mon_data = '0;
`ifdef RETIRE_TRACE_FILTER_EN
   logic [6:0]    filter_opcode = '0;
   logic [6:0]    filter_mask = '0;
`endif
   logic          trace_tvalid;
   logic          trace_tready = 1'b0;
   logic [RW-1:0] trace_tdata;
   logic [4:0]    level;
   logic [15:0]   drop_count;

   int            n_tests = 0;
   int            n_fail = 0;
   logic [31:0]   tb_cyc;
   logic [RW-1:0] exp_q [$];

   retire_trace_fifo dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .mon_tvalid   (mon_tvalid),
      .mon_tready   (mon_tready),
      .mon_pc       (mon_pc),
      .mon_opcode   (mon_opcode),
      .mon_rd       (mon_rd),
      .mon_data     (mon_data),
`ifdef RETIRE_TRACE_FILTER_EN
      .filter_opcode(filter_opcode),
      .filter_mask  (filter_mask),
`endif
      .trace_tvalid (trace_tvalid),
      .trace_tready (trace_tready),
      .trace_tdata  (trace_tdata),
      .level        (level),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   // Independent cycle reference: cycles elapsed since reset release.
   always @(posedge clk or negedge rst) begin
      if (!rst) tb_cyc <= '0;
      else      tb_cyc <= tb_cyc + 32'd1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pop that the sink takes must match the scoreboard head.
   always @(negedge clk) begin
      if (rst && trace_tvalid && trace_tready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_record: got %0h expected none", trace_tdata);
         end else begin
            check("record", 128'(trace_tdata), 128'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                         input logic [31:0] d, input bit acc);
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_pc     = pc;
      mon_opcode = op;
      mon_rd     = rd;
      mon_data   = d;
      if (acc) exp_q.push_back({tb_cyc, pc, op, rd, d});
      step();
      mon_tvalid = 1'b0;
      mon_tready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("rst_tvalid", 128'(trace_tvalid), 128'(0));
      check("rst_level",  128'(level),        128'(0));
      check("rst_drop",   128'(drop_count),   128'(0));
      check("rst_tdata",  128'(trace_tdata),  128'(0));
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic drain(input int max_cycles);
      trace_tready = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         if (level == 5'd0) break;
         step();
      end
      check("drain_level", 128'(level), 128'(0));
      check("sb_empty", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // 1: single record, stamped at cycle 5, visible one cycle later
      enable = 1'b1;
      trace_tready = 1'b1;
      repeat (5) step();
      check("t1_not_early", 128'(trace_tvalid), 128'(0));
      retire(32'h100, 7'h13, 5'd3, 32'hA, 1'b1);
      check("t1_tvalid", 128'(trace_tvalid), 128'(1));
      check("t1_tdata", 128'(trace_tdata), 128'({32'd5, 32'h100, 7'h13, 5'd3, 32'hA}));
      step();
      check("t1_level", 128'(level), 128'(0));

      // 2: fill to 16 under backpressure, then three overflows
      trace_tready = 1'b0;
      for (int i = 0; i < 16; i++)
         retire(32'(32'h200 + i * 4), 7'h33, 5'(i), 32'(32'hD000 + i), 1'b1);
      check("t2_level_full", 128'(level), 128'(16));
      check("t2_drop0", 128'(drop_count), 128'(0));
      for (int i = 0; i < 3; i++)
         retire(32'(32'h300 + i * 4), 7'h33, 5'd1, 32'hDEAD, 1'b0);
      check("t2_drop3", 128'(drop_count), 128'(3));
      check("t2_level_held", 128'(level), 128'(16));

      // 3: full FIFO, capture with simultaneous pop is accepted and emerges last
      trace_tready = 1'b1;
      retire(32'h400, 7'h03, 5'd7, 32'hBEEF, 1'b1);
      check("t3_level", 128'(level), 128'(16));
      check("t3_drop", 128'(drop_count), 128'(3));
      drain(40);

      // 4: backpressure holds tdata stable
      trace_tready = 1'b0;
      retire(32'h500, 7'h23, 5'd9, 32'h1234, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("t4_tvalid", 128'(trace_tvalid), 128'(1));
         check("t4_hold", 128'(trace_tdata), 128'(exp_q[0]));
         step();
      end
      trace_tready = 1'b1;
      step();
      check("t4_popped", 128'(level), 128'(0));

      // 5: incomplete handshake and disabled capture are ignored
      trace_tready = 1'b0;
      mon_tvalid = 1'b1;
      mon_tready = 1'b0;
      step();
      mon_tvalid = 1'b0;
      check("t5_no_handshake", 128'(level), 128'(0));
      enable = 1'b0;
      retire(32'h600, 7'h13, 5'd2, 32'h55, 1'b0);
      check("t5_disabled", 128'(level), 128'(0));
      check("t5_drop", 128'(drop_count), 128'(3));
      enable = 1'b1;
`ifdef RETIRE_TRACE_FILTER_EN
      filter_mask = 7'h7F;
      filter_opcode = 7'h03;
      retire(32'h700, 7'h33, 5'd4, 32'h77, 1'b0);
      check("t5_filtered", 128'(level), 128'(0));
      check("t5_filter_nodrop", 128'(drop_count), 128'(3));
      retire(32'h704, 7'h03, 5'd5, 32'h78, 1'b1);
      check("t5_filter_hit", 128'(level), 128'(1));
      drain(10);
      filter_mask = 7'h00;
`endif

      // 6: asynchronous reset mid-stream with 5 entries and 2 drops
      do_reset();
      trace_tready = 1'b0;
      for (int i = 0; i < 16; i++)
         retire(32'(32'h800 + i * 4), 7'h13, 5'(i), 32'(i), 1'b1);
      for (int i = 0; i < 2; i++)
         retire(32'h900, 7'h13, 5'd0, 32'h0, 1'b0);
      trace_tready = 1'b1;
      repeat (11) step();
      trace_tready = 1'b0;
      check("t6_level5", 128'(level), 128'(5));
      check("t6_drop2", 128'(drop_count), 128'(2));
      do_reset();
      check("t6_after_release", 128'(trace_tvalid), 128'(0));
      repeat (3) step();
      retire(32'hA00, 7'h67, 5'd1, 32'hCAFE, 1'b1);
      check("t6_stamp", 128'(trace_tdata[RW-1:RW-32]), 128'(3));
      drain(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
